// File: rtl/fadd_issue_ctrl.sv
// Issue/collect stage around the fixed-latency fadd core: operand sign
// conditioning, tag tracking through the core pipeline, credit-guarded response FIFO.
module fadd_issue_ctrl #(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_op1,
  input  logic [31:0]      req_op2,
  input  logic             req_sub,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      add_op1,
  output logic [31:0]      add_op2,
  input  logic [31:0]      add_result,
  input  logic             add_valid,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_uflow,
  output logic             busy
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned EW = 32 + 1 + TAG_W;

  logic [CW-1:0]    credits_q, credits_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [LATENCY:0] pv_q;
  logic [TAG_W-1:0] pt_q [LATENCY+1];
  logic [31:0]      add_op1_q, add_op2_q;

  logic acc, pop, push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign req_ready = (credits_q != '0);
  assign acc       = req_valid & req_ready;
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign push      = pv_q[LATENCY];
  assign busy      = (credits_q != CW'(DEPTH));
  assign add_op1   = add_op1_q;
  assign add_op2   = add_op2_q;

  assign {rsp_result, rsp_uflow, rsp_tag} = mem_q[rd_ptr_q];

  always_comb begin
    credits_d = credits_q;
    case ({acc, pop})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   credits_d = credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // The core evaluates op1 - op2, so an add must present op2 with its sign flipped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      add_op1_q <= '0;
      add_op2_q <= '0;
    end else if (acc) begin
      add_op1_q <= req_op1;
      add_op2_q <= req_sub ? req_op2 : {~req_op2[31], req_op2[30:0]};
    end
  end

  // Tag pipe mirrors the core's occupancy; it never stalls because the core never does.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pv_q <= '0;
      for (int unsigned i = 0; i <= LATENCY; i++) pt_q[i] <= '0;
    end else begin
      pv_q    <= {pv_q[LATENCY-1:0], acc};
      pt_q[0] <= req_tag;
      for (int unsigned i = 1; i <= LATENCY; i++) pt_q[i] <= pt_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credits_q <= CW'(DEPTH);
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      credits_q <= credits_d;
      count_q   <= count_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {add_result, ~add_valid, pt_q[LATENCY]};
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && count_q == CW'(DEPTH)));

endmodule

// File: tb/tb_fadd_issue_ctrl.sv
// Scoreboard bench for fadd_issue_ctrl with a behavioural fadd core stub
// (real-arithmetic op1 - op2, underflow when the result drops below normal range).
module tb_fadd_issue_ctrl;

  localparam int unsigned LAT   = 3;
  localparam int unsigned DEP   = 4;
  localparam int unsigned TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid, req_ready, req_sub;
  logic [31:0]      req_op1, req_op2;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      add_op1, add_op2, add_result;
  logic             add_valid;
  logic             rsp_valid, rsp_ready, rsp_uflow, busy;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;

  fadd_issue_ctrl #(.LATENCY(LAT), .DEPTH(DEP), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_sub(req_sub), .req_tag(req_tag),
    .add_op1(add_op1), .add_op2(add_op2),
    .add_result(add_result), .add_valid(add_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_tag(rsp_tag), .rsp_uflow(rsp_uflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      res;
    logic             uf;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   rsp_mode = 0;  // 0: always ready, 1: never ready, 2: random

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic real s2r(input logic [31:0] s);
    logic [10:0] de;
    logic [63:0] d;
    if (s[30:23] == 8'h0) return 0.0;
    de = 11'(s[30:23]) + 11'd896;
    d  = {s[31], de, s[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  // Returns {valid, result} for a - b, valid = 0 when the result underflows.
  function automatic logic [32:0] core_fn(input logic [31:0] a, input logic [31:0] b);
    real         r;
    logic [63:0] d;
    int          se;
    r = s2r(a) - s2r(b);
    if (r == 0.0) return {1'b1, 32'h0};
    d  = $realtobits(r);
    se = int'(d[62:52]) - 896;
    if (se <= 0)   return {1'b0, d[63], 31'h0};
    if (se >= 255) return {1'b1, d[63], 8'hFF, 23'h0};
    return {1'b1, d[63], se[7:0], d[51:29]};
  endfunction

  // Core stub: samples operands every edge, result valid LAT edges after sampling.
  logic [63:0] cpipe [LAT];
  initial for (int i = 0; i < LAT; i++) cpipe[i] = '0;
  always @(posedge clk) begin
    cpipe[0] <= {add_op1, add_op2};
    for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
  end
  always_comb {add_valid, add_result} = core_fn(cpipe[LAT-1][63:32], cpipe[LAT-1][31:0]);

  task automatic do_req(input logic [31:0] op1, input logic [31:0] op2, input logic sub,
                        input logic [TAG_W-1:0] tag, input bit fixed,
                        input logic [31:0] fres, input logic fuf);
    int    waited = 0;
    exp_t  e;
    logic [31:0] eff2;
    logic [32:0] m;
    forever begin
      @(negedge clk);
      req_valid = 1'b1; req_op1 = op1; req_op2 = op2; req_sub = sub; req_tag = tag;
      if (req_ready) break;
      waited++;
      if (waited > 200) begin
        chk("accept_timeout", 64'(waited), 64'd0);
        req_valid = 1'b0;
        return;
      end
    end
    eff2 = sub ? op2 : (op2 ^ 32'h8000_0000);
    m    = core_fn(op1, eff2);
    e.res = fixed ? fres : m[31:0];
    e.uf  = fixed ? fuf : ~m[32];
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk); #1;
    chk("add_op1", 64'(add_op1), 64'(op1));
    chk("add_op2", 64'(add_op2), 64'(eff2));
    req_valid = 1'b0;
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [31:0] v;
    v = $urandom;
    v[30:23] = 8'(100 + $urandom_range(0, 54));
    return v;
  endfunction

  // Monitor: owns rsp_ready, compares each popped head against the scoreboard.
  initial begin
    bit          held = 0;
    logic [37:0] held_v = '0;
    exp_t        e;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        held = 0;
        rsp_ready = 1'b0;
        continue;
      end
      if (held) begin
        chk("rsp_valid_stable", 64'(rsp_valid), 64'd1);
        chk("rsp_head_stable", 64'({rsp_result, rsp_uflow, rsp_tag}), 64'(held_v));
      end
      case (rsp_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'b0;
        default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
      held = rsp_valid && !rsp_ready;
      held_v = {rsp_result, rsp_uflow, rsp_tag};
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 64'(rsp_tag), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
          chk("rsp_result", 64'(rsp_result), 64'(e.res));
          chk("rsp_uflow", 64'(rsp_uflow), 64'(e.uf));
        end
      end
    end
  end

  task automatic drain(input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_op1 = '0; req_op2 = '0; req_sub = 1'b0; req_tag = '0;
    #7;
    chk("rst_add_op1", 64'(add_op1), 64'd0);
    chk("rst_add_op2", 64'(add_op2), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk); reset = 1'b1;

    // Single add with latency check; head is held until released.
    rsp_mode = 1;
    do_req(32'h3F80_0000, 32'h4000_0000, 1'b0, 5'd5, 1'b1, 32'h4040_0000, 1'b0);
    chk("busy_inflight", 64'(busy), 64'd1);
    repeat (3) @(posedge clk);
    #1 chk("rsp_valid_at_E3", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    #1 chk("rsp_valid_at_E4", 64'(rsp_valid), 64'd1);
    rsp_mode = 0;
    drain(20);
    repeat (2) @(posedge clk);
    #1 chk("busy_after_pop", 64'(busy), 64'd0);

    do_req(32'h4040_0000, 32'h3F80_0000, 1'b1, 5'd9, 1'b1, 32'h4000_0000, 1'b0);
    do_req(32'h0080_0001, 32'h0080_0000, 1'b1, 5'd17, 1'b1, 32'h0000_0000, 1'b1);
    drain(30);

    // Backpressure: only DEPTH requests accepted while the consumer stalls.
    rsp_mode = 1;
    for (int t = 0; t < 4; t++) do_req(rnd_fp(), rnd_fp(), 1'($urandom), 5'(t), 1'b0, '0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req_valid = 1'b1; req_tag = 5'd4;
      chk("req_ready_no_credit", 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    #1 chk("head_tag_0", 64'(rsp_tag), 64'd0);
    rsp_mode = 0;
    do_req(rnd_fp(), rnd_fp(), 1'b0, 5'd4, 1'b0, '0, 1'b0);
    do_req(rnd_fp(), rnd_fp(), 1'b1, 5'd5, 1'b0, '0, 1'b0);
    drain(40);

    // Saturated traffic with the consumer always ready.
    for (int t = 0; t < 20; t++) do_req(rnd_fp(), rnd_fp(), 1'($urandom), 5'(t), 1'b0, '0, 1'b0);
    drain(40);

    // Random traffic and random consumer stalls.
    rsp_mode = 2;
    for (int t = 0; t < 60; t++) begin
      do_req(rnd_fp(), rnd_fp(), 1'($urandom), 5'($urandom), 1'b0, '0, 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    rsp_mode = 0;
    drain(100);

    // Reset mid-flight discards everything outstanding.
    rsp_mode = 1;
    for (int t = 0; t < 3; t++) do_req(rnd_fp(), rnd_fp(), 1'b0, 5'(20 + t), 1'b0, '0, 1'b0);
    repeat (5) @(posedge clk);
    #1 chk("pre_rst_rsp_valid", 64'(rsp_valid), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    rsp_mode = 0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("post_rst_req_ready", 64'(req_ready), 64'd1);
    repeat (12) @(posedge clk);
    chk("no_stale_rsp", 64'(exp_q.size()), 64'd0);
    #1 chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    do_req(32'h3F80_0000, 32'h4000_0000, 1'b0, 5'd7, 1'b1, 32'h4040_0000, 1'b0);
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
